// File: rtl/fir_pkg.sv
// Shared constants, coefficient table and enums for the time-shared red/IR FIR filter.
package fir_pkg;

  localparam int NUM_TAPS = 22;
  localparam int DW       = 8;
  localparam int AW       = 20;
  localparam int CW       = 9;
  localparam int TW       = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_t;

  typedef enum logic {
    CH_RED = 1'b0,
    CH_IR  = 1'b1
  } fir_chan_t;

  // Symmetric low-pass taps; every entry fits in 9 unsigned bits
  localparam logic [CW-1:0] COEFF [NUM_TAPS] = '{
    9'd2,   9'd10,  9'd16,  9'd28,  9'd43,  9'd60,  9'd78,  9'd95,
    9'd111, 9'd122, 9'd128, 9'd128, 9'd122, 9'd111, 9'd95,  9'd78,
    9'd60,  9'd43,  9'd28,  9'd16,  9'd10,  9'd2
  };

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Sample handshakes and filtered-result outputs for the red and IR channels.
interface fir_mac_scheduler_if;
  import fir_pkg::*;

  logic          red_valid;
  logic [DW-1:0] red_sample;
  logic          red_ready;
  logic          ir_valid;
  logic [DW-1:0] ir_sample;
  logic          ir_ready;
  logic [AW-1:0] red_out;
  logic [AW-1:0] ir_out;
  logic          red_out_valid;
  logic          ir_out_valid;
  logic          busy;

  modport master (
    output red_valid, red_sample, ir_valid, ir_sample,
    input  red_ready, ir_ready, red_out, ir_out,
    input  red_out_valid, ir_out_valid, busy
  );

  modport slave (
    input  red_valid, red_sample, ir_valid, ir_sample,
    output red_ready, ir_ready, red_out, ir_out,
    output red_out_valid, ir_out_valid, busy
  );

endinterface

// File: rtl/fir_delay_line.sv
// 22-entry circular sample history; wptr marks the newest sample, tap k reads (wptr-k) mod 22.
module fir_delay_line
  import fir_pkg::*;
(
  input  logic          CLK_Filter,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic [TW-1:0] tap,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [NUM_TAPS];
  logic [TW-1:0] wptr;
  logic [TW-1:0] wptr_nxt;
  logic [TW-1:0] rd_idx;

  assign wptr_nxt = (wptr == TW'(NUM_TAPS - 1)) ? '0 : wptr + TW'(1);

  // Modulo-32 intermediate is harmless: the true result always lands in 0..21
  assign rd_idx = (wptr >= tap) ? (wptr - tap) : (wptr + TW'(NUM_TAPS) - tap);
  assign dout   = mem[rd_idx];

  always_ff @(posedge CLK_Filter or posedge rst_n) begin
    if (rst_n) begin
      wptr <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wptr_nxt] <= din;
      wptr          <= wptr_nxt;
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// One 8x9 MAC time-shared between red and IR FIR channels, round-robin on ties.
//   state | meaning
//   IDLE  | ready offered to the granted channel, waiting for a handshake
//   MAC   | one tap per cycle, k = 0..21, accumulating into acc
//   DONE  | result presented on the served channel's *_out with a one-cycle valid
module fir_mac_scheduler
  import fir_pkg::*;
(
  input logic           CLK_Filter,
  input logic           rst_n,
  fir_mac_scheduler_if.slave bus
);

  fir_state_t    state;
  fir_chan_t     chan;
  fir_chan_t     last_served;
  logic [TW-1:0] tap;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_nxt;
  logic [DW-1:0] red_x;
  logic [DW-1:0] ir_x;
  logic [DW-1:0] x_sel;
  logic          idle;
  logic          gnt_red;
  logic          gnt_ir;
  logic          red_rdy;
  logic          ir_rdy;

  // Ready is suppressed while reset is held so no sample slips in during reset
  assign idle    = (state == IDLE) && !rst_n;
  assign gnt_red = bus.red_valid && (!bus.ir_valid || (last_served == CH_IR));
  assign gnt_ir  = bus.ir_valid && !gnt_red;
  assign red_rdy = idle && gnt_red;
  assign ir_rdy  = idle && gnt_ir;

  assign bus.red_ready = red_rdy;
  assign bus.ir_ready  = ir_rdy;

  fir_delay_line u_red_line (
    .CLK_Filter (CLK_Filter),
    .rst_n      (rst_n),
    .push       (red_rdy),
    .din        (bus.red_sample),
    .tap        (tap),
    .dout       (red_x)
  );

  fir_delay_line u_ir_line (
    .CLK_Filter (CLK_Filter),
    .rst_n      (rst_n),
    .push       (ir_rdy),
    .din        (bus.ir_sample),
    .tap        (tap),
    .dout       (ir_x)
  );

  assign x_sel   = (chan == CH_RED) ? red_x : ir_x;
  assign acc_nxt = acc + (AW'(x_sel) * AW'(COEFF[tap]));

  always_ff @(posedge CLK_Filter or posedge rst_n) begin
    if (rst_n) begin
      state            <= IDLE;
      chan             <= CH_IR;
      last_served      <= CH_IR;
      tap              <= '0;
      acc              <= '0;
      bus.red_out      <= '0;
      bus.ir_out       <= '0;
      bus.red_out_valid <= 1'b0;
      bus.ir_out_valid <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.red_out_valid <= 1'b0;
      bus.ir_out_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (red_rdy || ir_rdy) begin
            chan        <= red_rdy ? CH_RED : CH_IR;
            last_served <= red_rdy ? CH_RED : CH_IR;
            tap         <= '0;
            acc         <= '0;
            state       <= MAC;
            bus.busy    <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          // Final tap: publish the completed sum so it is visible throughout DONE
          if (tap == TW'(NUM_TAPS - 1)) begin
            state <= DONE;
            if (chan == CH_RED) begin
              bus.red_out       <= acc_nxt;
              bus.red_out_valid <= 1'b1;
            end else begin
              bus.ir_out       <= acc_nxt;
              bus.ir_out_valid <= 1'b1;
            end
          end else begin
            tap <= tap + TW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Scoreboard bench: sample history per channel, convolution reference, decoupled output monitor.
module tb_fir_mac_scheduler;

  localparam int H [22] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128,
                            128, 122, 111, 95, 78, 60, 43, 28, 16, 10, 2};

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  typedef struct {
    int ch;
    int cyc;
  } hs_t;

  logic CLK_Filter = 1'b0;
  logic rst_n      = 1'b0;

  always #5 CLK_Filter = ~CLK_Filter;

  fir_mac_scheduler_if bus();

  fir_mac_scheduler dut (
    .CLK_Filter (CLK_Filter),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t exp_red[$];
  exp_t exp_ir[$];
  int   hist_red[$];
  int   hist_ir[$];
  hs_t  hs_log[$];
  int   red_seen[$];
  int   ir_seen[$];
  int   last_red  = 0;
  int   last_ir   = 0;
  int   last_hs   = 0;
  bit   hs_active = 1'b0;

  always @(posedge CLK_Filter) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Direct convolution over the newest-first history; missing history counts as zero
  function automatic int conv(int hist[$]);
    int s = 0;
    for (int k = 0; k < 22; k++) begin
      if (k < hist.size()) s += H[k] * hist[k];
    end
    return s;
  endfunction

  always @(negedge CLK_Filter) begin
    exp_t e;
    bit   exp_busy;
    if (rst_n) begin
      exp_red.delete();
      exp_ir.delete();
      hist_red.delete();
      hist_ir.delete();
      hs_log.delete();
      red_seen.delete();
      ir_seen.delete();
      last_red  = 0;
      last_ir   = 0;
      hs_active = 1'b0;
      check("reset red_out", int'(bus.red_out), 0);
      check("reset ir_out", int'(bus.ir_out), 0);
      check("reset red_out_valid", int'(bus.red_out_valid), 0);
      check("reset ir_out_valid", int'(bus.ir_out_valid), 0);
      check("reset busy", int'(bus.busy), 0);
      check("reset ready", int'(bus.red_ready | bus.ir_ready), 0);
    end else begin
      exp_busy = hs_active && (cyc - last_hs >= 1) && (cyc - last_hs <= 23);
      check("busy", int'(bus.busy), int'(exp_busy));
      check("dual ready", int'(bus.red_ready & bus.ir_ready), 0);
      if (bus.busy) check("ready while busy", int'(bus.red_ready | bus.ir_ready), 0);

      if (bus.red_out_valid) begin
        if (exp_red.size() == 0) begin
          check("unexpected red_out_valid", 1, 0);
          last_red = int'(bus.red_out);
        end else begin
          e = exp_red.pop_front();
          check("red_out value", int'(bus.red_out), e.val);
          check("red_out latency", cyc, e.cyc + 23);
          last_red = e.val;
          red_seen.push_back(int'(bus.red_out));
        end
      end else begin
        check("red_out hold", int'(bus.red_out), last_red);
      end

      if (bus.ir_out_valid) begin
        if (exp_ir.size() == 0) begin
          check("unexpected ir_out_valid", 1, 0);
          last_ir = int'(bus.ir_out);
        end else begin
          e = exp_ir.pop_front();
          check("ir_out value", int'(bus.ir_out), e.val);
          check("ir_out latency", cyc, e.cyc + 23);
          last_ir = e.val;
          ir_seen.push_back(int'(bus.ir_out));
        end
      end else begin
        check("ir_out hold", int'(bus.ir_out), last_ir);
      end

      if (bus.red_valid && bus.red_ready) begin
        hist_red.push_front(int'(bus.red_sample));
        if (hist_red.size() > 22) void'(hist_red.pop_back());
        exp_red.push_back('{conv(hist_red), cyc});
        hs_log.push_back('{0, cyc});
        last_hs   = cyc;
        hs_active = 1'b1;
      end else if (bus.ir_valid && bus.ir_ready) begin
        hist_ir.push_front(int'(bus.ir_sample));
        if (hist_ir.size() > 22) void'(hist_ir.pop_back());
        exp_ir.push_back('{conv(hist_ir), cyc});
        hs_log.push_back('{1, cyc});
        last_hs   = cyc;
        hs_active = 1'b1;
      end
    end
  end

  task automatic wait_hs(int n, string name);
    int i = 0;
    while (hs_log.size() < n && i < 200) begin
      @(posedge CLK_Filter);
      i++;
    end
    if (hs_log.size() < n) check(name, hs_log.size(), n);
  endtask

  task automatic send(int ch, int v);
    int n0;
    @(posedge CLK_Filter);
    #1;
    n0 = hs_log.size();
    if (ch == 0) begin
      bus.red_valid  = 1'b1;
      bus.red_sample = v[7:0];
    end else begin
      bus.ir_valid  = 1'b1;
      bus.ir_sample = v[7:0];
    end
    wait_hs(n0 + 1, "send timeout");
    #1;
    bus.red_valid = 1'b0;
    bus.ir_valid  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK_Filter);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge CLK_Filter);
    #1 rst_n = 1'b0;
  endtask

  task automatic settle();
    repeat (30) @(posedge CLK_Filter);
  endtask

  task automatic impulse(string tag);
    send(0, 1);
    for (int i = 0; i < 21; i++) send(0, 0);
    settle();
    check({tag, " red count"}, red_seen.size(), 22);
    for (int i = 0; i < 22 && i < red_seen.size(); i++) check({tag, " red tap"}, red_seen[i], H[i]);
    check({tag, " ir untouched"}, int'(bus.ir_out), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bus.red_valid  = 1'b0;
    bus.ir_valid   = 1'b0;
    bus.red_sample = '0;
    bus.ir_sample  = '0;
    #2 rst_n = 1'b1;
    repeat (3) @(posedge CLK_Filter);

    // Tie from reset: both valid, round-robin starting with red
    #1;
    bus.red_valid  = 1'b1;
    bus.ir_valid   = 1'b1;
    bus.red_sample = 8'($urandom);
    bus.ir_sample  = 8'($urandom);
    rst_n          = 1'b0;
    for (int i = 0; i < 200 && hs_log.size() < 4; i++) begin
      @(posedge CLK_Filter);
      #1;
      bus.red_sample = 8'($urandom);
      bus.ir_sample  = 8'($urandom);
    end
    bus.red_valid = 1'b0;
    bus.ir_valid  = 1'b0;
    check("tie handshake count", hs_log.size(), 4);
    for (int i = 0; i < 4 && i < hs_log.size(); i++) begin
      check("tie order", hs_log[i].ch, i % 2);
      if (i > 0) check("tie spacing", hs_log[i].cyc - hs_log[i-1].cyc, 24);
    end
    settle();

    do_reset();
    impulse("impulse");

    for (int i = 0; i < 22; i++) send(1, 255);
    settle();
    check("step count", ir_seen.size(), 22);
    if (ir_seen.size() == 22) begin
      check("step first", ir_seen[0], 510);
      check("step full", ir_seen[21], 353430);
    end

    // Backpressure: IR raised mid red computation must wait for IDLE
    hs_log.delete();
    @(posedge CLK_Filter);
    #1;
    bus.red_valid  = 1'b1;
    bus.red_sample = 8'($urandom);
    wait_hs(1, "bp red timeout");
    #1 bus.red_valid = 1'b0;
    t0 = (hs_log.size() > 0) ? hs_log[0].cyc : cyc;
    for (int i = 0; i < 100 && cyc < t0 + 5; i++) begin
      @(posedge CLK_Filter);
      #1;
    end
    bus.ir_valid  = 1'b1;
    bus.ir_sample = 8'($urandom);
    wait_hs(2, "bp ir timeout");
    #1 bus.ir_valid = 1'b0;
    if (hs_log.size() >= 2) begin
      check("bp ir channel", hs_log[1].ch, 1);
      check("bp ir accept cycle", hs_log[1].cyc, t0 + 24);
    end
    settle();

    // Reset in the middle of a computation
    hs_log.delete();
    @(posedge CLK_Filter);
    #1;
    bus.red_valid  = 1'b1;
    bus.red_sample = 8'd77;
    wait_hs(1, "reset-mid timeout");
    #1 bus.red_valid = 1'b0;
    t0 = (hs_log.size() > 0) ? hs_log[0].cyc : cyc;
    for (int i = 0; i < 100 && cyc < t0 + 10; i++) begin
      @(posedge CLK_Filter);
      #1;
    end
    rst_n = 1'b1;
    repeat (2) @(posedge CLK_Filter);
    #1 rst_n = 1'b0;
    repeat (40) @(posedge CLK_Filter);
    impulse("post-reset impulse");

    for (int v = 1; v <= 30; v++) send(0, v);
    settle();

    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK_Filter);
      #1;
      bus.red_valid  = ($urandom_range(0, 3) == 0);
      bus.ir_valid   = ($urandom_range(0, 3) == 0);
      bus.red_sample = 8'($urandom);
      bus.ir_sample  = 8'($urandom);
    end
    bus.red_valid = 1'b0;
    bus.ir_valid  = 1'b0;
    settle();
    check("red results drained", exp_red.size(), 0);
    check("ir results drained", exp_ir.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_mac_scheduler.md
FIR_MAC_SCHEDULER -- requirements
Module: fir_mac_scheduler

Interface
REQ-001 NUM_TAPS, 22, number of filter taps; the coefficient table is fixed.
REQ-002 DW, 8, sample width; AW, 20, accumulator/output width.
REQ-003 CLK_Filter  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-high.
REQ-005 red_valid  input  1  red-channel sample offered.
REQ-006 red_sample  input  8  red ADC sample, unsigned.
REQ-007 red_ready  output  1  red sample accepted this cycle when high together with red_valid.
REQ-008 ir_valid / ir_sample / ir_ready  input / input / output  1 / 8 / 1  IR channel, same semantics.
REQ-009 red_out, ir_out  output  20 each  last filtered result per channel, unsigned.
REQ-010 red_out_valid, ir_out_valid  output  1 each  one-cycle pulse when the matching *_out updates.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 One shared MAC (8-bit sample x 9-bit unsigned coefficient, 20-bit accumulate) SHALL be time-shared between the red and IR channels.
REQ-013 Coefficients h[0..21] SHALL be 2,10,16,28,43,60,78,95,111,122,128,128,122,111,95,78,60,43,28,16,10,2.
REQ-014 FSM states SHALL be IDLE, MAC, DONE; IDLE->MAC on handshake, MAC->DONE after tap 21, DONE->IDLE unconditionally.
REQ-015 *_ready SHALL be high only in IDLE and only for the granted channel; it may depend combinationally on *_valid.
REQ-016 Grant in IDLE: only one valid -> that channel; both valid -> the channel not served last (round-robin); last_served resets to IR, so red wins the first tie.
REQ-017 On handshake at cycle T, the sample SHALL be written into the granted channel's 22-entry circular delay line, advancing its write pointer with wrap 21->0.
REQ-018 Cycles T+1..T+22: MAC processes tap k=0..21, accumulating h[k]*x[n-k], where x[n-k] is read at (wptr-k) mod 22; the accumulator clears at T+1.
REQ-019 Cycle T+23 (DONE): the granted channel's *_out takes the accumulator value and its *_out_valid pulses high for exactly one cycle.
REQ-020 The next handshake SHALL be possible no earlier than T+24; throughput is 1 sample per 24 cycles.
REQ-021 Arithmetic SHALL be unsigned, with no saturation; maximum sum 255*1386=353430 fits in 20 bits.
REQ-022 Channels SHALL be isolated: delay line, write pointer and *_out of one channel are never touched while the other is served.
REQ-023 *_valid asserted outside IDLE SHALL be ignored, with the sample not captured, until the FSM returns to IDLE.
REQ-024 *_out SHALL hold its value between *_out_valid pulses.

Reset
REQ-025 Asserting rst_n at any time, including mid-MAC, SHALL force IDLE, clear the accumulator, both delay lines (all 0), both write pointers (0), red_out/ir_out (0), both *_out_valid (0), busy (0) and set last_served=IR.
REQ-026 A computation interrupted by reset SHALL produce no *_out_valid pulse.

Structure
REQ-027 Package fir_pkg SHALL hold NUM_TAPS, DW, AW, the coefficient table constant and the FSM state enum.
REQ-028 A sub-module fir_delay_line (22x8 circular buffer, write port, indexed read port, async-reset to zero) SHALL be instantiated once per channel.

Verification
REQ-029 Impulse: red sample 1 then 21 samples of 0 -> successive red_out = 2,10,16,28,...,10,2; ir_out stays 0.
REQ-030 Step: 22 IR samples of 255 -> 22nd ir_out = 353430; earlier outputs equal 255 x partial coefficient sums (first 510).
REQ-031 Tie: red_valid and ir_valid held high from reset -> accept order red, ir, red, ir; handshakes 24 cycles apart; out_valid at T+23.
REQ-032 Backpressure: ir_valid asserted at T+5 of a red computation -> ir_ready stays low until IDLE at T+24, then ir is accepted.
REQ-033 Reset at T+10 of a computation -> no out_valid pulse, outputs 0; the next impulse reproduces REQ-029 exactly.
REQ-034 Wrap: 30 consecutive red samples with values 1..30 -> each red_out equals the software reference convolution, and the pointer wraps without glitch.
